uart_fifo_tx: RTL and testbench

FIFO-draining UART transmitter: pops one word at a time from the upstream synchronous FIFO (registered read data, one-cycle read latency) and serialises it as 8N1/8N2 asynchronous serial, LSB first. It sits directly downstream of the common FIFO on the transmit path, so producers write bytes into the FIFO and this block empties it at line rate. Output is a single idle-high TX line plus a busy flag.

---
 rtl/uart_fifo_tx_pkg.sv | 24 ++
 rtl/uart_fifo_tx_if.sv | 27 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_fifo_tx.sv | 112 +++++++++++
 tb/tb_uart_fifo_tx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmit path.
// Holds the frame state encoding and the baud divider arithmetic, so a future receiver can reuse them.
package uart_fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_e;

    // Clock cycles per serial bit, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Counter width for a divider; clamps to one bit so illegal dividers still elaborate far enough to report.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// FIFO read port plus serial output of the UART transmitter.
// The master side is the transmitter; the slave side is the FIFO and line observer.
interface uart_fifo_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 tx;
    logic                 busy;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output tx,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  tx,
        input  busy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: tick_c is high on the last cycle of every DIV-cycle period.
// restart forces the period to begin again on the following cycle.
module uart_baud_gen
    import uart_fifo_tx_pkg::*;
#(
    parameter int unsigned DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick_c
);
    localparam int unsigned CNT_W = cnt_width(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops words from an upstream synchronous FIFO and sends them as 8N1/8N2 frames.
// One word per frame; tx, busy and fifo_rd_en are all registered.
module uart_fifo_tx
    import uart_fifo_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_fifo_tx_if.master bus
);
    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + STOP_BITS);

    if (DIV < 2) begin : g_bad_div
        $error("uart_fifo_tx: CLK_HZ / BAUD must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_fifo_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 2) begin : g_bad_data
        $error("uart_fifo_tx: DATA_BITS must be at least 2");
    end

    tx_state_e            state;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 baud_tick_c;
    logic                 baud_restart_c;

    // The bit period restarts as the word is latched, so the start bit is exactly DIV cycles.
    assign baud_restart_c = (state == LATCH);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (baud_restart_c),
        .tick_c  (baud_tick_c)
    );

    // Frame sequencer; each output is set on the transition into the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            shift          <= '0;
            bit_cnt        <= '0;
            bus.tx         <= 1'b1;
            bus.fifo_rd_en <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.fifo_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        state          <= FETCH;
                        bus.fifo_rd_en <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    shift   <= bus.fifo_rd_data;
                    bit_cnt <= '0;
                    bus.tx  <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (baud_tick_c) begin
                        bus.tx <= shift[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick_c) begin
                        shift <= shift >> 1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            bus.tx  <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            bus.tx  <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_tick_c) begin
                        if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                            bit_cnt  <= '0;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.tx   <= 1'b1;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: cycle-exact frame checks plus a line decoder fed by a byte scoreboard.
// dut1 runs 8N1 and dut2 runs 8N2, both at DIV=12.
module tb_uart_fifo_tx;
    localparam int DIV = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_fifo_tx_if #(.DATA_BITS(8)) bus1 ();
    uart_fifo_tx_if #(.DATA_BITS(8)) bus2 ();

    uart_fifo_tx #(
        .CLK_HZ(12_000_000), .BAUD(1_000_000), .DATA_BITS(8), .STOP_BITS(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    uart_fifo_tx #(
        .CLK_HZ(12_000_000), .BAUD(1_000_000), .DATA_BITS(8), .STOP_BITS(2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo1_q[$];
    logic [7:0] fifo2_q[$];
    logic [7:0] exp1_q[$];
    logic [7:0] exp2_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream FIFO models: registered read data, one-cycle latency.
    always @(posedge clk) begin
        if (bus1.fifo_rd_en && fifo1_q.size() != 0) bus1.fifo_rd_data <= fifo1_q.pop_front();
        if (bus2.fifo_rd_en && fifo2_q.size() != 0) bus2.fifo_rd_data <= fifo2_q.pop_front();
    end

    function automatic logic get_tx(input int which);
        return (which == 1) ? bus1.tx : bus2.tx;
    endfunction

    function automatic logic [2:0] obs(input int which);
        if (which == 1) return {bus1.fifo_rd_en, bus1.busy, bus1.tx};
        return {bus2.fifo_rd_en, bus2.busy, bus2.tx};
    endfunction

    task automatic drive_empty(input int which, input logic v);
        if (which == 1) bus1.fifo_empty = v;
        else bus2.fifo_empty = v;
    endtask

    function automatic int sb_size(input int which);
        return (which == 1) ? exp1_q.size() : exp2_q.size();
    endfunction

    function automatic logic [7:0] sb_pop(input int which);
        if (which == 1) return exp1_q.pop_front();
        return exp2_q.pop_front();
    endfunction

    // Expected {fifo_rd_en, busy, tx} in cycle k of a frame whose pop request was seen in cycle 0.
    function automatic logic [2:0] exp_obs(input logic [7:0] b, input int sb, input int k);
        int   last_k;
        logic rd;
        logic bz;
        logic t;
        last_k = 3 + DIV * (9 + sb);
        rd = (k == 1);
        bz = (k >= 1 && k < last_k);
        if (k < 3) t = 1'b1;
        else if (k < 3 + DIV) t = 1'b0;
        else if (k < 3 + 9 * DIV) t = b[3'((k - 3) / DIV - 1)];
        else t = 1'b1;
        return {rd, bz, t};
    endfunction

    // Sends one byte and checks every cycle up to and including the first IDLE cycle.
    // mode 0: fifo_empty rises after the pop; 1: toggles every cycle; 2: held low for a back-to-back frame.
    task automatic frame(input int which, input logic [7:0] b, input int sb, input int mode);
        int   last_k;
        logic e;
        last_k = 3 + DIV * (9 + sb);
        if (which == 1) begin
            fifo1_q.push_back(b);
            exp1_q.push_back(b);
        end else begin
            fifo2_q.push_back(b);
            exp2_q.push_back(b);
        end
        e = 1'b0;
        drive_empty(which, e);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            chk($sformatf("frame%0d_%02h_k%0d", which, b, k), 32'(obs(which)), 32'(exp_obs(b, sb, k)));
            if (mode == 1) e = (k < last_k - 1) ? ~e : 1'b1;
            else if (mode == 0) e = 1'b1;
            drive_empty(which, e);
        end
    endtask

    // Line decoder: samples each bit mid-period and compares against the scoreboard.
    task automatic rx_monitor(input int which, input int sb);
        logic       prev;
        logic       abort;
        logic       stop_ok;
        logic [7:0] b;
        logic [7:0] e;
        int         last;
        prev = 1'b1;
        last = DIV * (9 + sb - 1) + DIV / 2;
        forever begin
            @(negedge clk);
            if (!rst && prev && !get_tx(which)) begin
                b       = '0;
                abort   = 1'b0;
                stop_ok = 1'b1;
                for (int c = 1; c <= last; c++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    if (c >= DIV && c < 9 * DIV && (c % DIV) == DIV / 2) b[3'(c / DIV - 1)] = get_tx(which);
                    if (c >= 9 * DIV && (c % DIV) == DIV / 2) stop_ok = stop_ok & get_tx(which);
                end
                if (!abort) begin
                    if (sb_size(which) == 0) begin
                        chk($sformatf("rx%0d_unexpected_%02h", which, b), 32'd1, 32'd0);
                    end else begin
                        e = sb_pop(which);
                        chk($sformatf("rx%0d_byte", which), 32'(b), 32'(e));
                        chk($sformatf("rx%0d_stop", which), 32'(stop_ok), 32'd1);
                    end
                end
            end
            prev = get_tx(which);
        end
    endtask

    initial rx_monitor(1, 1);
    initial rx_monitor(2, 2);

    initial begin
        logic seen_rd;
        logic seen_busy;
        logic seen_low;

        rst               = 1'b1;
        bus1.fifo_empty   = 1'b1;
        bus2.fifo_empty   = 1'b1;
        bus1.fifo_rd_data = '0;
        bus2.fifo_rd_data = '0;

        repeat (3) @(negedge clk);
        chk("reset_state1", 32'(obs(1)), 32'b001);
        chk("reset_state2", 32'(obs(2)), 32'b001);
        rst = 1'b0;

        // Idle with an empty FIFO: no pops, line high, not busy.
        seen_rd = 1'b0; seen_busy = 1'b0; seen_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            seen_rd   = seen_rd | bus1.fifo_rd_en | bus2.fifo_rd_en;
            seen_busy = seen_busy | bus1.busy | bus2.busy;
            seen_low  = seen_low | ~bus1.tx | ~bus2.tx;
        end
        chk("idle_rd_en", 32'(seen_rd), 32'd0);
        chk("idle_busy", 32'(seen_busy), 32'd0);
        chk("idle_tx_low", 32'(seen_low), 32'd0);

        frame(1, 8'hA5, 1, 0);
        repeat (5) @(negedge clk);

        frame(1, 8'h96, 1, 1);
        repeat (5) @(negedge clk);

        frame(1, 8'h00, 1, 2);
        frame(1, 8'hFF, 1, 0);
        repeat (5) @(negedge clk);

        frame(2, 8'h3C, 2, 0);
        repeat (5) @(negedge clk);

        // Reset in the middle of a data bit of 0x00; the popped word must be dropped.
        fifo1_q.push_back(8'h00);
        bus1.fifo_empty = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bus1.fifo_empty = 1'b1;
        end
        chk("pre_reset_k50", 32'(obs(1)), 32'b010);
        rst = 1'b1;
        #1;
        chk("async_reset", 32'(obs(1)), 32'b001);
        @(negedge clk);
        rst = 1'b0;
        seen_rd = 1'b0; seen_busy = 1'b0; seen_low = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            seen_rd   = seen_rd | bus1.fifo_rd_en;
            seen_busy = seen_busy | bus1.busy;
            seen_low  = seen_low | ~bus1.tx;
        end
        chk("post_reset_rd_en", 32'(seen_rd), 32'd0);
        chk("post_reset_busy", 32'(seen_busy), 32'd0);
        chk("post_reset_tx_low", 32'(seen_low), 32'd0);

        chk("sb1_left", 32'(exp1_q.size()), 32'd0);
        chk("sb2_left", 32'(exp2_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
